// File: rtl/manchester_rx_ctrl.sv
// Manchester (IEEE 802.3) receive controller: line sync, interval timing,
// preamble/SFD framing FSM and byte assembly behind a valid/ready holding register.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   data_in      raw asynchronous Manchester line
//   enable       0 holds the framer in HUNT and drops any partial byte
//   rx_ready     consumer accepts rx_data
//   clr_ovr      clears overrun
//   rx_data      decoded byte, LSB received first
//   rx_valid     rx_data holds an unconsumed byte
//   lock         framer is decoding data bits
//   err          one-cycle framing error pulse
//   overrun      sticky: a byte was dropped because the holding register was full
module manchester_rx_ctrl #(
    parameter int HALF_MIN   = 3,
    parameter int HALF_MAX   = 7,
    parameter int FULL_MAX   = 14,
    parameter int CNT_W      = 8,
    parameter int SYNC_EDGES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data_in,
    input  logic       enable,
    input  logic       rx_ready,
    input  logic       clr_ovr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       lock,
    output logic       err,
    output logic       overrun
);

    localparam int LC_W = $clog2(SYNC_EDGES + 1);

    localparam logic [CNT_W-1:0] C_HMIN = CNT_W'(HALF_MIN);
    localparam logic [CNT_W-1:0] C_HMAX = CNT_W'(HALF_MAX);
    localparam logic [CNT_W-1:0] C_FMAX = CNT_W'(FULL_MAX);
    localparam logic [CNT_W-1:0] C_TOUT = CNT_W'(FULL_MAX + 1);
    localparam logic [CNT_W-1:0] C_SAT  = '1;
    localparam logic [LC_W-1:0]  L_LAST = LC_W'(SYNC_EDGES - 1);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SFD  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t           state, state_n;
    logic             s1, s2, s3;
    logic             edg;
    logic [CNT_W-1:0] cnt;
    logic [LC_W-1:0]  lcnt, lcnt_n;
    logic             half, half_n;
    logic [7:0]       shreg;
    logic [2:0]       bitcnt;
    logic             err_n;
    logic             shift_en;
    logic             is_short, is_long, is_bad, tout;
    logic             byte_done, load;

    // Three-flop chain: s1/s2 resynchronise, s3 delays s2 for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= data_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edg = s2 ^ s3;

    // Interval since the previous edge; reads N at an edge N clocks later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (edg) begin
            cnt <= CNT_W'(1);
        end else if (cnt != C_SAT) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        is_short = edg && (cnt >= C_HMIN) && (cnt <= C_HMAX);
        is_long  = edg && (cnt > C_HMAX) && (cnt <= C_FMAX);
        is_bad   = edg && !is_short && !is_long;
        tout     = !edg && (cnt == C_TOUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
            lcnt  <= '0;
            half  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            lcnt  <= lcnt_n;
            half  <= half_n;
            err   <= err_n;
        end
    end

    // half=1 means the last edge was a bit boundary, so the next
    // short edge is the mid-bit one that carries data.
    always_comb begin
        state_n  = state;
        lcnt_n   = lcnt;
        half_n   = half;
        err_n    = 1'b0;
        shift_en = 1'b0;
        if (!enable) begin
            state_n = HUNT;
            lcnt_n  = '0;
            half_n  = 1'b0;
        end else begin
            unique case (state)
                HUNT: begin
                    if (is_long) begin
                        if (lcnt == L_LAST) begin
                            state_n = SFD;
                            lcnt_n  = '0;
                            half_n  = 1'b0;
                        end else begin
                            lcnt_n = lcnt + LC_W'(1);
                        end
                    end else if (is_short || is_bad) begin
                        lcnt_n = '0;
                    end
                end
                SFD: begin
                    if (is_short && !half) begin
                        half_n = 1'b1;
                    end else if (is_short) begin
                        half_n = 1'b0;
                        if (s2) begin
                            state_n = DATA;
                        end else begin
                            state_n = HUNT;
                            err_n   = 1'b1;
                        end
                    end else if (is_bad || (is_long && half)) begin
                        state_n = HUNT;
                        half_n  = 1'b0;
                        err_n   = 1'b1;
                    end else if (tout) begin
                        state_n = HUNT;
                        half_n  = 1'b0;
                    end
                end
                DATA: begin
                    if (is_short && !half) begin
                        half_n = 1'b1;
                    end else if (is_short) begin
                        half_n   = 1'b0;
                        shift_en = 1'b1;
                    end else if (is_long && !half) begin
                        shift_en = 1'b1;
                    end else if (is_long || is_bad) begin
                        state_n = HUNT;
                        half_n  = 1'b0;
                        err_n   = 1'b1;
                    end else if (tout) begin
                        state_n = HUNT;
                        half_n  = 1'b0;
                        err_n   = (bitcnt != 3'd0);
                    end
                end
                default: begin
                    state_n = HUNT;
                    lcnt_n  = '0;
                    half_n  = 1'b0;
                end
            endcase
        end
    end

    assign lock      = (state == DATA);
    assign byte_done = shift_en && (bitcnt == 3'd7);
    assign load      = byte_done && (!rx_valid || rx_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            bitcnt   <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            // Outside DATA any partial byte is discarded.
            if (state_n != DATA) begin
                shreg  <= '0;
                bitcnt <= '0;
            end else if (shift_en) begin
                shreg  <= {s2, shreg[7:1]};
                bitcnt <= bitcnt + 3'd1;
            end
            if (load) begin
                rx_data  <= {s2, shreg[7:1]};
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (byte_done && !load) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
